ef_i2c_line_conditioner: RTL and testbench

//   Pad-side conditioning stage between the SCL/SDA pads and the I2C master core's
//   scl_i/scl_o/scl_t and sda_i/sda_o/sda_t pins.

---
 rtl/ef_i2c_line_conditioner.sv | 178 +++++++++++++++++
 tb/tb_ef_i2c_line_conditioner.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_i2c_line_conditioner.sv
// ef_i2c_line_conditioner
// Sits between the SCL/SDA pads and the I2C master core. Each incoming line
// is synchronised and glitch-filtered. The open-drain pad enables are formed
// from the master's pins. Bus START/STOP are detected, bus-busy is tracked,
// and lines held low for too long are flagged.

module ef_i2c_line_conditioner #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl_pad_i,
  input  logic                 sda_pad_i,
  input  logic                 scl_o_i,
  input  logic                 scl_t_i,
  input  logic                 sda_o_i,
  input  logic                 sda_t_i,
  output logic                 scl_pad_o,
  output logic                 scl_pad_oen_o,
  output logic                 sda_pad_o,
  output logic                 sda_pad_oen_o,
  output logic                 scl_f_o,
  output logic                 sda_f_o,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 start_o,
  output logic                 stop_o,
  output logic                 bus_busy_o,
  output logic                 scl_stuck_o,
  output logic                 sda_stuck_o
);

  // FILTER_LEN is at most 15, so a 4-bit run counter is always enough
  localparam int               CNT_W     = 4;
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);

  // two-flop synchronisers
  logic sclSync1_q, sclSync2_q;
  logic sdaSync1_q, sdaSync2_q;

  // glitch filters
  logic             sclFilt_q, sclFilt_d;
  logic             sdaFilt_q, sdaFilt_d;
  logic [CNT_W-1:0] sclFiltCnt_q, sclFiltCnt_d;
  logic [CNT_W-1:0] sdaFiltCnt_q, sdaFiltCnt_d;

  // previous filtered values for edge detection
  logic sclPrev_q, sdaPrev_q;

  // bus condition pulses and busy flag
  logic startPulse_q, startPulse_d;
  logic stopPulse_q, stopPulse_d;
  logic busBusy_q, busBusy_d;

  // stuck-low detection
  logic [TIMEOUT_W-1:0] sclStuckCnt_q, sclStuckCnt_d;
  logic [TIMEOUT_W-1:0] sdaStuckCnt_q, sdaStuckCnt_d;
  logic                 sclStuck_q, sclStuck_d;
  logic                 sdaStuck_q, sdaStuck_d;

  logic timeoutEn;

  // Open drain: the pad only ever pulls low, and only when the master drives a 0
  assign scl_pad_o     = 1'b0;
  assign sda_pad_o     = 1'b0;
  assign scl_pad_oen_o = scl_t_i | scl_o_i;
  assign sda_pad_oen_o = sda_t_i | sda_o_i;

  assign timeoutEn = (timeout_i != '0);

  // SCL filter: accept a new level only after FILTER_LEN consecutive disagreeing samples
  always_comb begin
    sclFilt_d    = sclFilt_q;
    sclFiltCnt_d = '0;
    if (sclSync2_q != sclFilt_q) begin
      if (sclFiltCnt_q == FILT_LAST) begin
        sclFilt_d = sclSync2_q;
      end else begin
        sclFiltCnt_d = sclFiltCnt_q + CNT_W'(1);
      end
    end
  end

  // SDA filter: same acceptance rule as SCL
  always_comb begin
    sdaFilt_d    = sdaFilt_q;
    sdaFiltCnt_d = '0;
    if (sdaSync2_q != sdaFilt_q) begin
      if (sdaFiltCnt_q == FILT_LAST) begin
        sdaFilt_d = sdaSync2_q;
      end else begin
        sdaFiltCnt_d = sdaFiltCnt_q + CNT_W'(1);
      end
    end
  end

  // START/STOP need SCL high on both sides of the SDA edge, so a simultaneous SCL change never counts
  always_comb begin
    startPulse_d = sclPrev_q & sclFilt_q & sdaPrev_q & ~sdaFilt_q;
    stopPulse_d  = sclPrev_q & sclFilt_q & ~sdaPrev_q & sdaFilt_q;
    busBusy_d    = busBusy_q;
    if (startPulse_d) begin
      busBusy_d = 1'b1;
    end else if (stopPulse_d) begin
      busBusy_d = 1'b0;
    end
  end

  // SCL stuck-low: count filtered-low cycles, saturating, and compare against the live threshold
  always_comb begin
    sclStuckCnt_d = '0;
    sclStuck_d    = 1'b0;
    if (!sclFilt_q) begin
      sclStuckCnt_d = (sclStuckCnt_q == '1) ? sclStuckCnt_q : sclStuckCnt_q + TIMEOUT_W'(1);
      sclStuck_d    = timeoutEn && (sclStuckCnt_q >= timeout_i);
    end
  end

  // SDA stuck-low: same counting and compare as SCL
  always_comb begin
    sdaStuckCnt_d = '0;
    sdaStuck_d    = 1'b0;
    if (!sdaFilt_q) begin
      sdaStuckCnt_d = (sdaStuckCnt_q == '1) ? sdaStuckCnt_q : sdaStuckCnt_q + TIMEOUT_W'(1);
      sdaStuck_d    = timeoutEn && (sdaStuckCnt_q >= timeout_i);
    end
  end

  // All state registers; idle bus lines read as high after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sclSync1_q    <= 1'b1;
      sclSync2_q    <= 1'b1;
      sdaSync1_q    <= 1'b1;
      sdaSync2_q    <= 1'b1;
      sclFilt_q     <= 1'b1;
      sdaFilt_q     <= 1'b1;
      sclFiltCnt_q  <= '0;
      sdaFiltCnt_q  <= '0;
      sclPrev_q     <= 1'b1;
      sdaPrev_q     <= 1'b1;
      startPulse_q  <= 1'b0;
      stopPulse_q   <= 1'b0;
      busBusy_q     <= 1'b0;
      sclStuckCnt_q <= '0;
      sdaStuckCnt_q <= '0;
      sclStuck_q    <= 1'b0;
      sdaStuck_q    <= 1'b0;
    end else begin
      sclSync1_q    <= scl_pad_i;
      sclSync2_q    <= sclSync1_q;
      sdaSync1_q    <= sda_pad_i;
      sdaSync2_q    <= sdaSync1_q;
      sclFilt_q     <= sclFilt_d;
      sdaFilt_q     <= sdaFilt_d;
      sclFiltCnt_q  <= sclFiltCnt_d;
      sdaFiltCnt_q  <= sdaFiltCnt_d;
      sclPrev_q     <= sclFilt_q;
      sdaPrev_q     <= sdaFilt_q;
      startPulse_q  <= startPulse_d;
      stopPulse_q   <= stopPulse_d;
      busBusy_q     <= busBusy_d;
      sclStuckCnt_q <= sclStuckCnt_d;
      sdaStuckCnt_q <= sdaStuckCnt_d;
      sclStuck_q    <= sclStuck_d;
      sdaStuck_q    <= sdaStuck_d;
    end
  end

  assign scl_f_o     = sclFilt_q;
  assign sda_f_o     = sdaFilt_q;
  assign start_o     = startPulse_q;
  assign stop_o      = stopPulse_q;
  assign bus_busy_o  = busBusy_q;
  assign scl_stuck_o = sclStuck_q;
  assign sda_stuck_o = sdaStuck_q;

endmodule

// File: tb/tb_ef_i2c_line_conditioner.sv
// tb_ef_i2c_line_conditioner
// Directed scenarios plus a randomized run against a behavioural model of the
// line conditioner.

module tb_ef_i2c_line_conditioner;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT_W  = 16;
  localparam int HIST       = FILTER_LEN + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclPad = 1'b1, sdaPad = 1'b1;
  logic sclO = 1'b1, sclT = 1'b1, sdaO = 1'b1, sdaT = 1'b1;
  logic [TIMEOUT_W-1:0] timeout = '0;
  logic sclPadO, sclOen, sdaPadO, sdaOen;
  logic sclF, sdaF, startO, stopO, busyO, sclStuck, sdaStuck;

  int total = 0;
  int bad   = 0;

  ef_i2c_line_conditioner #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk(clk), .rst(rst),
    .scl_pad_i(sclPad), .sda_pad_i(sdaPad),
    .scl_o_i(sclO), .scl_t_i(sclT), .sda_o_i(sdaO), .sda_t_i(sdaT),
    .scl_pad_o(sclPadO), .scl_pad_oen_o(sclOen),
    .sda_pad_o(sdaPadO), .sda_pad_oen_o(sdaOen),
    .scl_f_o(sclF), .sda_f_o(sdaF),
    .timeout_i(timeout),
    .start_o(startO), .stop_o(stopO), .bus_busy_o(busyO),
    .scl_stuck_o(sclStuck), .sda_stuck_o(sdaStuck)
  );

  always #5 clk = ~clk;

  // Behavioural model: line 0 = SCL, line 1 = SDA.
  // mHist[l][j] is the pad level sampled j edges ago; the level seen by the
  // filter is the one from two edges back. A line changes when the last
  // FILTER_LEN such levels all disagree with its current filtered value.
  logic   mHist [2][HIST];
  logic   mFilt [2];
  logic   mPrev [2];
  logic   mStuck [2];
  logic   mStart, mStop, mBusy;
  longint lowStart [2];
  longint edgeNo;

  initial begin
    edgeNo = 0;
    for (int l = 0; l < 2; l++) begin
      for (int j = 0; j < HIST; j++) mHist[l][j] = 1'b1;
      mFilt[l] = 1'b1; mPrev[l] = 1'b1; mStuck[l] = 1'b0; lowStart[l] = 0;
    end
    mStart = 1'b0; mStop = 1'b0; mBusy = 1'b0;
  end

  // Advance the model on each rising edge using the levels present before it
  always @(posedge clk) begin
    logic   padNow [2];
    logic   allDiffer;
    longint lowCycles;
    edgeNo++;
    padNow[0] = sclPad;
    padNow[1] = sdaPad;
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        for (int j = 0; j < HIST; j++) mHist[l][j] = 1'b1;
        mFilt[l] = 1'b1; mPrev[l] = 1'b1; mStuck[l] = 1'b0;
      end
      mStart = 1'b0; mStop = 1'b0; mBusy = 1'b0;
    end else begin
      mStart = mPrev[0] && mFilt[0] && mPrev[1] && !mFilt[1];
      mStop  = mPrev[0] && mFilt[0] && !mPrev[1] && mFilt[1];
      if (mStart) mBusy = 1'b1;
      else if (mStop) mBusy = 1'b0;
      for (int l = 0; l < 2; l++) begin
        if (mFilt[l]) begin
          mStuck[l] = 1'b0;
        end else begin
          lowCycles = edgeNo - lowStart[l] - 1;
          if (lowCycles > 65535) lowCycles = 65535;
          mStuck[l] = (timeout != 0) && (lowCycles >= longint'(timeout));
        end
        mPrev[l] = mFilt[l];
        for (int j = HIST - 1; j > 0; j--) mHist[l][j] = mHist[l][j-1];
        mHist[l][0] = padNow[l];
        allDiffer = 1'b1;
        for (int j = 2; j < HIST; j++) if (mHist[l][j] == mFilt[l]) allDiffer = 1'b0;
        if (allDiffer) begin
          mFilt[l] = ~mFilt[l];
          if (!mFilt[l]) lowStart[l] = edgeNo;
        end
      end
    end
  end

  task automatic waitCycle;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) waitCycle;
    total++; if (sclF !== 1'b1) begin bad++; $display("[TB] FAIL reset_scl_f got=%b want=1", sclF); end
    total++; if (sdaF !== 1'b1) begin bad++; $display("[TB] FAIL reset_sda_f got=%b want=1", sdaF); end
    total++; if (startO !== 1'b0) begin bad++; $display("[TB] FAIL reset_start got=%b want=0", startO); end
    total++; if (stopO !== 1'b0) begin bad++; $display("[TB] FAIL reset_stop got=%b want=0", stopO); end
    total++; if (busyO !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busyO); end
    total++; if (sclStuck !== 1'b0) begin bad++; $display("[TB] FAIL reset_scl_stuck got=%b want=0", sclStuck); end
    total++; if (sdaStuck !== 1'b0) begin bad++; $display("[TB] FAIL reset_sda_stuck got=%b want=0", sdaStuck); end
    rst = 1'b0;
    repeat (4) waitCycle;
  endtask

  task automatic test_glitch;
    sdaPad = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      waitCycle;
      total++; if (sdaF !== 1'b1) begin bad++; $display("[TB] FAIL glitch_sda_f cyc=%0d got=%b want=1", i, sdaF); end
      total++; if (startO !== 1'b0) begin bad++; $display("[TB] FAIL glitch_start cyc=%0d got=%b want=0", i, startO); end
      if (i == 3) sdaPad = 1'b1;
    end
  endtask

  task automatic test_start;
    sdaPad = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      waitCycle;
      total++; if (sdaF !== (i < 6)) begin bad++; $display("[TB] FAIL start_sda_f cyc=%0d got=%b want=%b", i, sdaF, (i < 6)); end
      total++; if (startO !== (i == 7)) begin bad++; $display("[TB] FAIL start_pulse cyc=%0d got=%b want=%b", i, startO, (i == 7)); end
      total++; if (busyO !== (i >= 7)) begin bad++; $display("[TB] FAIL start_busy cyc=%0d got=%b want=%b", i, busyO, (i >= 7)); end
    end
  endtask

  // Expects the bus busy with SCL high and SDA low, as test_start leaves it
  task automatic test_stop;
    sclPad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      waitCycle;
      if (i == 10) sclPad = 1'b1;
      total++; if (startO !== 1'b0 || stopO !== 1'b0 || busyO !== 1'b1) begin
        bad++; $display("[TB] FAIL stop_clocking cyc=%0d got start=%b stop=%b busy=%b want 0 0 1", i, startO, stopO, busyO);
      end
    end
    sdaPad = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      waitCycle;
      total++; if (sdaF !== (i >= 6)) begin bad++; $display("[TB] FAIL stop_sda_f cyc=%0d got=%b want=%b", i, sdaF, (i >= 6)); end
      total++; if (stopO !== (i == 7)) begin bad++; $display("[TB] FAIL stop_pulse cyc=%0d got=%b want=%b", i, stopO, (i == 7)); end
      total++; if (busyO !== (i < 7)) begin bad++; $display("[TB] FAIL stop_busy cyc=%0d got=%b want=%b", i, busyO, (i < 7)); end
    end
  endtask

  task automatic test_repeated_start;
    sdaPad = 1'b0;
    repeat (10) waitCycle;
    total++; if (busyO !== 1'b1) begin bad++; $display("[TB] FAIL rstart_busy_first got=%b want=1", busyO); end
    sclPad = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      waitCycle;
      if (i == 10) sdaPad = 1'b1;
      if (i == 20) sclPad = 1'b1;
      total++; if (startO !== 1'b0 || stopO !== 1'b0 || busyO !== 1'b1) begin
        bad++; $display("[TB] FAIL rstart_setup cyc=%0d got start=%b stop=%b busy=%b want 0 0 1", i, startO, stopO, busyO);
      end
    end
    sdaPad = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      waitCycle;
      total++; if (startO !== (i == 7)) begin bad++; $display("[TB] FAIL rstart_pulse cyc=%0d got=%b want=%b", i, startO, (i == 7)); end
      total++; if (busyO !== 1'b1 || stopO !== 1'b0) begin bad++; $display("[TB] FAIL rstart_busy cyc=%0d got busy=%b stop=%b want 1 0", i, busyO, stopO); end
    end
    sdaPad = 1'b1;
    repeat (10) waitCycle;
    total++; if (busyO !== 1'b0) begin bad++; $display("[TB] FAIL rstart_final_busy got=%b want=0", busyO); end
  endtask

  task automatic test_stuck;
    timeout = 16'd100;
    sclPad  = 1'b0;
    for (int i = 1; i <= 110; i++) begin
      waitCycle;
      total++; if (sclStuck !== (i >= 107)) begin bad++; $display("[TB] FAIL stuck_rise cyc=%0d got=%b want=%b", i, sclStuck, (i >= 107)); end
      total++; if (sdaStuck !== 1'b0) begin bad++; $display("[TB] FAIL stuck_sda cyc=%0d got=%b want=0", i, sdaStuck); end
    end
    timeout = 16'd0;
    waitCycle;
    total++; if (sclStuck !== 1'b0) begin bad++; $display("[TB] FAIL stuck_disable got=%b want=0", sclStuck); end
    timeout = 16'd50;
    waitCycle;
    total++; if (sclStuck !== 1'b1) begin bad++; $display("[TB] FAIL stuck_lowered got=%b want=1", sclStuck); end
    timeout = 16'd0;
    sclPad  = 1'b1;
    repeat (10) waitCycle;
    total++; if (sclStuck !== 1'b0 || sclF !== 1'b1) begin bad++; $display("[TB] FAIL stuck_release got stuck=%b scl_f=%b want 0 1", sclStuck, sclF); end
    timeout = 16'd3;
    sclPad  = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      waitCycle;
      total++; if (sclStuck !== (i >= 10)) begin bad++; $display("[TB] FAIL stuck_restart cyc=%0d got=%b want=%b", i, sclStuck, (i >= 10)); end
    end
    sclPad  = 1'b1;
    timeout = 16'd0;
    repeat (10) waitCycle;
  endtask

  task automatic test_simultaneous;
    sclPad = 1'b0;
    sdaPad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      waitCycle;
      if (i == 10) begin sclPad = 1'b1; sdaPad = 1'b1; end
      total++; if (startO !== 1'b0 || stopO !== 1'b0 || busyO !== 1'b0) begin
        bad++; $display("[TB] FAIL simul_cond cyc=%0d got start=%b stop=%b busy=%b want 0 0 0", i, startO, stopO, busyO);
      end
      if (i == 8) begin
        total++; if (sclF !== 1'b0 || sdaF !== 1'b0) begin bad++; $display("[TB] FAIL simul_filtered got scl=%b sda=%b want 0 0", sclF, sdaF); end
      end
    end
  endtask

  task automatic test_reset_busy;
    sdaPad = 1'b0;
    repeat (10) waitCycle;
    total++; if (busyO !== 1'b1) begin bad++; $display("[TB] FAIL rbusy_pre got=%b want=1", busyO); end
    rst = 1'b1;
    waitCycle;
    total++; if (busyO !== 1'b0 || stopO !== 1'b0) begin bad++; $display("[TB] FAIL rbusy_drop got busy=%b stop=%b want 0 0", busyO, stopO); end
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      waitCycle;
      total++; if (startO !== (i == 7)) begin bad++; $display("[TB] FAIL rbusy_start cyc=%0d got=%b want=%b", i, startO, (i == 7)); end
      total++; if (busyO !== (i >= 7) || stopO !== 1'b0) begin bad++; $display("[TB] FAIL rbusy_busy cyc=%0d got busy=%b stop=%b want %b 0", i, busyO, stopO, (i >= 7)); end
    end
    sdaPad = 1'b1;
    repeat (10) waitCycle;
  endtask

  task automatic test_pad_enables;
    logic [3:0] c;
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      c = 4'(k);
      {sclO, sclT, sdaO, sdaT} = c;
      #1;
      total++; if (sclOen !== !(sclT == 1'b0 && sclO == 1'b0)) begin bad++; $display("[TB] FAIL oen_scl k=%0d got=%b", k, sclOen); end
      total++; if (sdaOen !== !(sdaT == 1'b0 && sdaO == 1'b0)) begin bad++; $display("[TB] FAIL oen_sda k=%0d got=%b", k, sdaOen); end
      total++; if (sclPadO !== 1'b0 || sdaPadO !== 1'b0) begin bad++; $display("[TB] FAIL pad_o k=%0d got scl=%b sda=%b want 0 0", k, sclPadO, sdaPadO); end
    end
    waitCycle;
    rst = 1'b0;
    {sclO, sclT, sdaO, sdaT} = 4'b1111;
    repeat (4) waitCycle;
  endtask

  task automatic test_random;
    logic [6:0] expVec, obsVec;
    int sclHold = 0, sdaHold = 0;
    for (int i = 0; i < 1500; i++) begin
      waitCycle;
      expVec = {mFilt[0], mFilt[1], mStart, mStop, mBusy, mStuck[0], mStuck[1]};
      obsVec = {sclF, sdaF, startO, stopO, busyO, sclStuck, sdaStuck};
      total++; if (obsVec !== expVec) begin bad++; $display("[TB] FAIL random_outputs cyc=%0d got=%b want=%b", i, obsVec, expVec); end
      total++; if (sclOen !== !(sclT == 1'b0 && sclO == 1'b0) || sdaOen !== !(sdaT == 1'b0 && sdaO == 1'b0)) begin
        bad++; $display("[TB] FAIL random_oen cyc=%0d got scl=%b sda=%b", i, sclOen, sdaOen);
      end
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 39) == 0) timeout = 16'($urandom_range(0, 12));
      {sclO, sclT, sdaO, sdaT} = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        sclPad = ~sclPad; sdaPad = ~sdaPad;
        sclHold = 8; sdaHold = 8;
      end else begin
        if (sclHold == 0) begin sclPad = 1'($urandom_range(0, 1)); sclHold = $urandom_range(1, 9); end
        else sclHold--;
        if (sdaHold == 0) begin sdaPad = 1'($urandom_range(0, 1)); sdaHold = $urandom_range(1, 9); end
        else sdaHold--;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    bad++;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting line conditioner bench");
    test_reset;
    test_glitch;
    test_start;
    test_stop;
    test_repeated_start;
    test_stuck;
    test_simultaneous;
    test_reset_busy;
    test_pad_enables;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
